gshare_predictor: RTL and testbench

Parametrised global-history (gshare) branch direction predictor for the fetch stage. A table of saturating counters is indexed by the PC XORed with a speculative global history register (GHR). Mispredicts repair the GHR, and a self-clearing init sweep sets every counter after reset. Fetch sends prediction requests; execute sends resolved outcomes carrying the history snapshot that was used at predict time.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_pht.sv | 65 ++++++
 rtl/gshare_predictor.sv | 116 +++++++++++
 tb/tb_gshare_predictor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package bp_pkg;

   // PC bits below this position are always zero for aligned instructions
   localparam int PC_ALIGN_BITS = 2;

   // Two-phase controller: sweep the table, then serve traffic
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Reset value of every counter: weakly taken (MSB set, rest clear)
   function automatic int ctr_init_val(input int ctr_bits);
      return 1 << (ctr_bits - 1);
   endfunction

   // Upper saturation point of a counter
   function automatic int ctr_max_val(input int ctr_bits);
      return (1 << ctr_bits) - 1;
   endfunction

   // Table index: word-aligned PC XOR zero-extended history, modulo depth
   function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                            input logic [31:0] hist,
                                            input int          index_bits);
      logic [31:0] mask;
      mask = (32'd1 << index_bits) - 32'd1;
      return ((pc >> PC_ALIGN_BITS) ^ hist) & mask;
   endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: saturating counters with one async read port,
// one read-modify-write update port and an init-sweep write override.
module bp_pht
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = 10,
   parameter int CTR_BITS   = 2
) (
   input  logic                  clk,
   input  logic                  init_en,
   input  logic [INDEX_BITS-1:0] init_idx,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output logic [CTR_BITS-1:0]   rd_ctr,
   input  logic                  upd_en,
   input  logic [INDEX_BITS-1:0] upd_idx,
   input  logic                  upd_taken
);

   localparam int DEPTH = 1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init_val(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_max_val(CTR_BITS));

   logic [CTR_BITS-1:0]   table_q [DEPTH];
   logic [CTR_BITS-1:0]   upd_old;
   logic [CTR_BITS-1:0]   upd_new;
   logic                  wr_en;
   logic [INDEX_BITS-1:0] wr_idx;
   logic [CTR_BITS-1:0]   wr_data;

   // Both reads see the pre-edge contents, which gives read-before-write
   assign rd_ctr  = table_q[rd_idx];
   assign upd_old = table_q[upd_idx];

   // Saturating increment/decrement of the counter being updated
   always_comb begin
      upd_new = upd_old;
      if (upd_taken) begin
         if (upd_old != CTR_MAX) upd_new = upd_old + CTR_BITS'(1);
      end else begin
         if (upd_old != '0) upd_new = upd_old - CTR_BITS'(1);
      end
   end

   // Write mux: the sweep owns the port while it runs
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      if (init_en) begin
         wr_en   = 1'b1;
         wr_idx  = init_idx;
         wr_data = CTR_INIT;
      end else if (upd_en) begin
         wr_en   = 1'b1;
         wr_idx  = upd_idx;
         wr_data = upd_new;
      end
   end

   // Counter storage; contents are defined by the sweep, not by reset
   always_ff @(posedge clk) begin
      if (wr_en) table_q[wr_idx] <= wr_data;
   end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: FSM, speculative GHR with mispredict repair,
// registered prediction response and saturating statistics.
//
// Handshake: there is no ready. In RUN every cycle with pred_valid=1 is a
// request answered exactly one cycle later with pred_resp_valid=1, and every
// cycle with upd_valid=1 is an update applied at that edge. In INIT both
// valids are dropped without effect.
module gshare_predictor
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = 10,
   parameter int HIST_BITS  = 8,
   parameter int CTR_BITS   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 init_done,
   input  logic                 pred_valid,
   input  logic [31:0]          pred_pc,
   output logic                 pred_resp_valid,
   output logic                 pred_taken,
   output logic [HIST_BITS-1:0] pred_hist,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic [HIST_BITS-1:0] upd_hist,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict,
   output logic [31:0]          upd_count,
   output logic [31:0]          miss_count,
   output logic                 dbg_state
);

   localparam int DEPTH = 1 << INDEX_BITS;
   localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(DEPTH - 1);

   state_t                state;
   logic [INDEX_BITS-1:0] init_ptr;
   logic [HIST_BITS-1:0]  ghr;

   logic                  run;
   logic [INDEX_BITS-1:0] pred_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [CTR_BITS-1:0]   rd_ctr;
   logic                  pred_bit;
   logic [HIST_BITS-1:0]  ghr_shift;
   logic [HIST_BITS-1:0]  ghr_repair;

   assign run       = (state == ST_RUN);
   assign dbg_state = run;

   assign pred_idx = INDEX_BITS'(bp_index(pred_pc, 32'(ghr), INDEX_BITS));
   assign upd_idx  = INDEX_BITS'(bp_index(upd_pc, 32'(upd_hist), INDEX_BITS));
   assign pred_bit = rd_ctr[CTR_BITS-1];

   // Truncating the concatenation drops the oldest bit; with one history bit
   // this leaves just the new bit
   assign ghr_shift  = HIST_BITS'({ghr, pred_bit});
   assign ghr_repair = HIST_BITS'({upd_hist, upd_taken});

   bp_pht #(
      .INDEX_BITS (INDEX_BITS),
      .CTR_BITS   (CTR_BITS)
   ) u_pht (
      .clk       (clk),
      .init_en   (state == ST_INIT),
      .init_idx  (init_ptr),
      .rd_idx    (pred_idx),
      .rd_ctr    (rd_ctr),
      .upd_en    (run && upd_valid),
      .upd_idx   (upd_idx),
      .upd_taken (upd_taken)
   );

   // Controller, history register, response registers and statistics
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= ST_INIT;
         init_ptr        <= '0;
         init_done       <= 1'b0;
         ghr             <= '0;
         pred_resp_valid <= 1'b0;
         pred_taken      <= 1'b0;
         pred_hist       <= '0;
         upd_count       <= '0;
         miss_count      <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               pred_resp_valid <= 1'b0;
               init_ptr        <= init_ptr + INDEX_BITS'(1);
               if (init_ptr == LAST_IDX) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               pred_resp_valid <= pred_valid;
               if (pred_valid) begin
                  pred_taken <= pred_bit;
                  pred_hist  <= ghr;
               end
               // Repair outranks the speculative shift of a concurrent request
               if (upd_valid && upd_mispredict) ghr <= ghr_repair;
               else if (pred_valid)             ghr <= ghr_shift;
               if (upd_valid) begin
                  if (upd_count != '1) upd_count <= upd_count + 32'd1;
                  if (upd_mispredict && (miss_count != '1))
                     miss_count <= miss_count + 32'd1;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor at default parameters.
module tb_gshare_predictor;

   logic        clk;
   logic        reset;
   logic        init_done;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_resp_valid;
   logic        pred_taken;
   logic [7:0]  pred_hist;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [7:0]  upd_hist;
   logic        upd_taken;
   logic        upd_mispredict;
   logic [31:0] upd_count;
   logic [31:0] miss_count;
   logic        dbg_state;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   gshare_predictor dut (
      .clk             (clk),
      .reset           (reset),
      .init_done       (init_done),
      .pred_valid      (pred_valid),
      .pred_pc         (pred_pc),
      .pred_resp_valid (pred_resp_valid),
      .pred_taken      (pred_taken),
      .pred_hist       (pred_hist),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_hist        (upd_hist),
      .upd_taken       (upd_taken),
      .upd_mispredict  (upd_mispredict),
      .upd_count       (upd_count),
      .miss_count      (miss_count),
      .dbg_state       (dbg_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pred_valid     = 1'b0;
      pred_pc        = '0;
      upd_valid      = 1'b0;
      upd_pc         = '0;
      upd_hist       = '0;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   // Pulse reset, then wait (bounded) for the sweep and check its length
   task automatic reset_and_init(input string tag);
      int edges;
      idle_inputs();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      edges = 0;
      while (!init_done && edges < 1100) begin
         tick();
         edges++;
      end
      check({tag, " init edges"}, edges, 1024);
   endtask

   task automatic predict(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [7:0] exp_hist);
      pred_valid = 1'b1;
      pred_pc    = pc;
      tick();
      pred_valid = 1'b0;
      check({tag, " resp_valid"}, 32'(pred_resp_valid), 32'd1);
      check({tag, " taken"}, 32'(pred_taken), 32'(exp_taken));
      check({tag, " hist"}, 32'(pred_hist), 32'(exp_hist));
   endtask

   task automatic update(input logic [31:0] pc, input logic [7:0] hist,
                         input logic taken, input logic mis);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_hist       = hist;
      upd_taken      = taken;
      upd_mispredict = mis;
      tick();
      upd_valid      = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   initial begin
      logic any_resp;
      logic any_done;

      // Reset values
      idle_inputs();
      reset = 1'b0;
      #2;
      check("rst init_done", 32'(init_done), 32'd0);
      check("rst resp_valid", 32'(pred_resp_valid), 32'd0);
      check("rst taken", 32'(pred_taken), 32'd0);
      check("rst hist", 32'(pred_hist), 32'd0);
      check("rst upd_count", upd_count, 32'd0);
      check("rst miss_count", miss_count, 32'd0);
      check("rst state", 32'(dbg_state), 32'd0);

      // Reset again 500 cycles into the sweep
      tick();
      reset = 1'b1;
      for (int i = 0; i < 500; i++) tick();
      reset = 1'b0;
      #1;
      check("midinit init_done", 32'(init_done), 32'd0);
      check("midinit state", 32'(dbg_state), 32'd0);
      tick();

      // Full sweep with traffic offered throughout; all of it must be dropped
      pred_valid     = 1'b1;
      pred_pc        = 32'h100;
      upd_valid      = 1'b1;
      upd_pc         = 32'h100;
      upd_hist       = 8'h00;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b1;
      reset          = 1'b1;
      any_resp = 1'b0;
      any_done = 1'b0;
      for (int i = 0; i < 1023; i++) begin
         tick();
         any_resp |= pred_resp_valid;
         any_done |= init_done;
      end
      idle_inputs();
      check("init early done", 32'(any_done), 32'd0);
      check("init resp seen", 32'(any_resp), 32'd0);
      tick();
      check("edge1024 init_done", 32'(init_done), 32'd1);
      check("edge1024 state", 32'(dbg_state), 32'd1);
      check("edge1024 resp_valid", 32'(pred_resp_valid), 32'd0);
      check("init upd_count", upd_count, 32'd0);
      check("init miss_count", miss_count, 32'd0);

      // Probe after sweep: every entry weakly taken, GHR grows 0,1,3,7,F
      predict("probe 0x100", 32'h100, 1'b1, 8'h00);
      predict("probe 0x0", 32'h0, 1'b1, 8'h01);
      predict("probe 0x104", 32'h104, 1'b1, 8'h03);
      predict("probe 0xffc", 32'hFFC, 1'b1, 8'h07);
      predict("probe highpc", 32'h1234_5000, 1'b1, 8'h0F);

      // Reset mid-RUN clears outputs immediately
      reset = 1'b0;
      #1;
      check("midrun resp_valid", 32'(pred_resp_valid), 32'd0);
      check("midrun hist", 32'(pred_hist), 32'd0);
      check("midrun taken", 32'(pred_taken), 32'd0);
      check("midrun state", 32'(dbg_state), 32'd0);

      // Counter walks down and saturates at 00; read-before-write
      reset_and_init("B");
      update(32'h40, 8'h00, 1'b0, 1'b0);
      update(32'h40, 8'h00, 1'b0, 1'b0);
      update(32'h40, 8'h00, 1'b0, 1'b0);
      pred_valid     = 1'b1;
      pred_pc        = 32'h40;
      upd_valid      = 1'b1;
      upd_pc         = 32'h40;
      upd_hist       = 8'h00;
      upd_taken      = 1'b1;
      upd_mispredict = 1'b0;
      tick();
      idle_inputs();
      check("B rbw resp_valid", 32'(pred_resp_valid), 32'd1);
      check("B rbw taken", 32'(pred_taken), 32'd0);
      check("B rbw hist", 32'(pred_hist), 32'd0);
      update(32'h40, 8'h00, 1'b1, 1'b0);
      predict("B after 2 up", 32'h40, 1'b1, 8'h00);
      check("B upd_count", upd_count, 32'd5);
      check("B miss_count", miss_count, 32'd0);

      // Upper saturation
      reset_and_init("C");
      for (int i = 0; i < 5; i++) update(32'h80, 8'h00, 1'b1, 1'b0);
      update(32'h80, 8'h00, 1'b0, 1'b0);
      predict("C sat", 32'h80, 1'b1, 8'h00);
      check("C upd_count", upd_count, 32'd6);

      // Speculative history and mispredict repair
      reset_and_init("D");
      predict("D req0", 32'h0, 1'b1, 8'h00);
      predict("D req1", 32'h4, 1'b1, 8'h01);
      predict("D req2", 32'h8, 1'b1, 8'h03);
      pred_valid     = 1'b1;
      pred_pc        = 32'hC;
      upd_valid      = 1'b1;
      upd_pc         = 32'h200;
      upd_hist       = 8'h05;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b1;
      tick();
      idle_inputs();
      check("D concur resp_valid", 32'(pred_resp_valid), 32'd1);
      check("D concur hist", 32'(pred_hist), 32'h07);
      check("D concur taken", 32'(pred_taken), 32'd1);
      check("D miss_count", miss_count, 32'd1);
      check("D upd_count", upd_count, 32'd1);
      predict("D repaired", 32'h0, 1'b1, 8'h0A);
      // Repaired update hit idx 0x80^0x05 = 0x85; reach it with GHR 0x15
      predict("D upd idx", 32'h240, 1'b0, 8'h15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
